// File: rtl/ctr_pkg.sv
// Shared types and helpers for the parametrised step counter: overflow policy,
// the fold (saturate/wrap) function and an elaboration-time parameter check.
`define CTR_PARAM_CHECK(label, cond, msg) \
  if (!(cond)) begin : label \
    $fatal(1, msg); \
  end

package ctr_pkg;

  typedef enum logic {
    OVF_SAT  = 1'b0,
    OVF_WRAP = 1'b1
  } ovf_e;

  typedef struct packed {
    logic signed [31:0] value;
    logic               bound;
  } fold_t;

  // Fold arithmetic is done in 32 bits, so counters are limited to this width.
  localparam int MAX_WIDTH = 30;

  // Brings a raw step result back into [lo, hi]. A single wrap is enough
  // because steps never exceed half the range.
  function automatic fold_t fold(input logic signed [31:0] raw,
                                 input int lo, input int hi, input ovf_e pol);
    fold_t r;
    r.value = raw;
    r.bound = 1'b0;
    if (raw > hi) begin
      r.bound = 1'b1;
      r.value = (pol == OVF_WRAP) ? lo + (raw - hi - 1) : hi;
    end else if (raw < lo) begin
      r.bound = 1'b1;
      r.value = (pol == OVF_WRAP) ? hi - (lo - raw - 1) : lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/param_step_counter_if.sv
// Control and status bundle of the step counter; the counter is the slave side.
interface param_step_counter_if #(
  parameter int WIDTH = 10
);
  logic                    en;
  logic                    mode;
  logic                    load;
  logic signed [WIDTH-1:0] load_val;
  logic signed [WIDTH-1:0] cnt;
  logic                    at_max;
  logic                    at_min;
  logic                    bound_evt;
  logic                    skip_evt;
  logic                    load_err;

  modport master (
    output en, mode, load, load_val,
    input  cnt, at_max, at_min, bound_evt, skip_evt, load_err
  );

  modport slave (
    input  en, mode, load, load_val,
    output cnt, at_max, at_min, bound_evt, skip_evt, load_err
  );
endinterface

// File: rtl/step_fold.sv
// Combinational base +/- step, computed two bits wider than the counter, then
// folded back into the legal range.
module step_fold
  import ctr_pkg::*;
#(
  parameter int   WIDTH   = 10,
  parameter int   CNT_MIN = -263,
  parameter int   CNT_MAX = 269,
  parameter int   UP_STEP = 4,
  parameter int   DN_STEP = 10,
  parameter ovf_e POLICY  = OVF_SAT
) (
  input  logic signed [WIDTH-1:0] i_base,
  input  logic                    i_mode,
  output logic signed [WIDTH-1:0] o_val,
  output logic                    o_bound
);
  localparam logic signed [WIDTH+1:0] LP_UP = (WIDTH+2)'(UP_STEP);
  localparam logic signed [WIDTH+1:0] LP_DN = (WIDTH+2)'(DN_STEP);

  logic signed [WIDTH+1:0] w_base;
  logic signed [WIDTH+1:0] w_raw;
  fold_t                   w_fold;

  assign w_base  = {{2{i_base[WIDTH-1]}}, i_base};
  assign w_raw   = i_mode ? (w_base + LP_UP) : (w_base - LP_DN);
  assign w_fold  = fold(32'(w_raw), CNT_MIN, CNT_MAX, POLICY);
  assign o_val   = w_fold.value[WIDTH-1:0];
  assign o_bound = w_fold.bound;
endmodule

// File: rtl/param_step_counter.sv
// Signed up/down step counter with enable, range-checked load, saturate/wrap
// overflow, forbidden-value skipping and registered status/event flags.
module param_step_counter
  import ctr_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int CNT_MIN  = -263,
  parameter int CNT_MAX  = 269,
  parameter int RST_VAL  = 17,
  parameter int UP_STEP  = 4,
  parameter int DN_STEP  = 10,
  parameter int SKIP_EN  = 1,
  parameter int SKIP_VAL = -47,
  parameter int WRAP     = 0
) (
  input logic                 clk,
  input logic                 rst,
  param_step_counter_if.slave bus
);
  `CTR_PARAM_CHECK(g_chk_width, WIDTH >= 2 && WIDTH <= MAX_WIDTH, "param_step_counter: WIDTH out of range")
  `CTR_PARAM_CHECK(g_chk_range, CNT_MIN < CNT_MAX && CNT_MIN >= -(1 << (WIDTH-1)) && CNT_MAX <= (1 << (WIDTH-1)) - 1, "param_step_counter: CNT_MIN/CNT_MAX illegal for WIDTH")
  `CTR_PARAM_CHECK(g_chk_rst, RST_VAL >= CNT_MIN && RST_VAL <= CNT_MAX && !(SKIP_EN != 0 && RST_VAL == SKIP_VAL), "param_step_counter: RST_VAL illegal")
  `CTR_PARAM_CHECK(g_chk_up, UP_STEP >= 1 && UP_STEP <= (CNT_MAX - CNT_MIN) / 2, "param_step_counter: UP_STEP out of range")
  `CTR_PARAM_CHECK(g_chk_dn, DN_STEP >= 1 && DN_STEP <= (CNT_MAX - CNT_MIN) / 2, "param_step_counter: DN_STEP out of range")
  `CTR_PARAM_CHECK(g_chk_skip, SKIP_VAL > CNT_MIN && SKIP_VAL < CNT_MAX, "param_step_counter: SKIP_VAL must lie strictly inside the range")
  `CTR_PARAM_CHECK(g_chk_flags, (SKIP_EN == 0 || SKIP_EN == 1) && (WRAP == 0 || WRAP == 1), "param_step_counter: SKIP_EN/WRAP must be 0 or 1")

  localparam ovf_e                    LP_POL        = (WRAP != 0) ? OVF_WRAP : OVF_SAT;
  localparam logic signed [WIDTH-1:0] LP_RST        = WIDTH'(RST_VAL);
  localparam logic signed [WIDTH-1:0] LP_MAX        = WIDTH'(CNT_MAX);
  localparam logic signed [WIDTH-1:0] LP_MIN        = WIDTH'(CNT_MIN);
  localparam logic signed [WIDTH-1:0] LP_SKIP       = WIDTH'(SKIP_VAL);
  localparam logic                    LP_RST_AT_MAX = (RST_VAL == CNT_MAX);
  localparam logic                    LP_RST_AT_MIN = (RST_VAL == CNT_MIN);

  logic signed [WIDTH-1:0] r_cnt;
  logic                    r_at_max, r_at_min, r_bound_evt, r_skip_evt, r_load_err;

  logic signed [WIDTH-1:0] w_step_val, w_skip_val, w_cnt_nxt;
  logic                    w_step_bound, w_skip_bound;
  logic                    w_load_ok, w_hit_skip;
  logic                    w_bound_nxt, w_skip_nxt, w_lerr_nxt;

  step_fold #(
    .WIDTH(WIDTH), .CNT_MIN(CNT_MIN), .CNT_MAX(CNT_MAX),
    .UP_STEP(UP_STEP), .DN_STEP(DN_STEP), .POLICY(LP_POL)
  ) u_step (
    .i_base(r_cnt), .i_mode(bus.mode), .o_val(w_step_val), .o_bound(w_step_bound)
  );

  // Re-step from the forbidden value; only used when the primary step lands on it.
  step_fold #(
    .WIDTH(WIDTH), .CNT_MIN(CNT_MIN), .CNT_MAX(CNT_MAX),
    .UP_STEP(UP_STEP), .DN_STEP(DN_STEP), .POLICY(LP_POL)
  ) u_skip (
    .i_base(LP_SKIP), .i_mode(bus.mode), .o_val(w_skip_val), .o_bound(w_skip_bound)
  );

  assign w_load_ok  = (32'(bus.load_val) >= CNT_MIN) && (32'(bus.load_val) <= CNT_MAX) &&
                      !(SKIP_EN != 0 && bus.load_val == LP_SKIP);
  assign w_hit_skip = (SKIP_EN != 0) && (w_step_val == LP_SKIP);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    w_cnt_nxt   = r_cnt;
    w_bound_nxt = 1'b0;
    w_skip_nxt  = 1'b0;
    w_lerr_nxt  = 1'b0;
    if (bus.load) begin
      if (w_load_ok) w_cnt_nxt  = bus.load_val;
      else           w_lerr_nxt = 1'b1;
    end else if (bus.en) begin
      if (w_hit_skip) begin
        w_cnt_nxt   = w_skip_val;
        w_skip_nxt  = 1'b1;
        w_bound_nxt = w_step_bound | w_skip_bound;
      end else begin
        w_cnt_nxt   = w_step_val;
        w_bound_nxt = w_step_bound;
      end
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt       <= LP_RST;
      r_at_max    <= LP_RST_AT_MAX;
      r_at_min    <= LP_RST_AT_MIN;
      r_bound_evt <= 1'b0;
      r_skip_evt  <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_at_max    <= (w_cnt_nxt == LP_MAX);
      r_at_min    <= (w_cnt_nxt == LP_MIN);
      r_bound_evt <= w_bound_nxt;
      r_skip_evt  <= w_skip_nxt;
      r_load_err  <= w_lerr_nxt;
    end
  end

  assign bus.cnt       = r_cnt;
  assign bus.at_max    = r_at_max;
  assign bus.at_min    = r_at_min;
  assign bus.bound_evt = r_bound_evt;
  assign bus.skip_evt  = r_skip_evt;
  assign bus.load_err  = r_load_err;
endmodule

// File: tb/tb_param_step_counter.sv
// Bench for param_step_counter: a saturating (default) and a wrapping instance
// driven in lockstep and compared against an arithmetic reference model.
module tb_param_step_counter;
  localparam int W     = 10;
  localparam int MIN   = -263;
  localparam int MAX   = 269;
  localparam int RSTV  = 17;
  localparam int UP    = 4;
  localparam int DN    = 10;
  localparam int SKIP  = -47;
  localparam int RANGE = MAX - MIN + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  param_step_counter_if #(.WIDTH(W)) bus0 ();
  param_step_counter_if #(.WIDTH(W)) bus1 ();

  param_step_counter #(.WRAP(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  param_step_counter #(.WRAP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int total = 0;
  int bad   = 0;

  int m_cnt  [2];
  bit m_bnd  [2];
  bit m_skp  [2];
  bit m_lerr [2];

  // Reference fold: clamp, or true modular reduction onto [MIN, MAX].
  function automatic int fold_m(input int raw, input bit wrap, output bit hit);
    hit = (raw > MAX) || (raw < MIN);
    if (!hit) return raw;
    if (wrap) return MIN + (((raw - MIN) % RANGE) + RANGE) % RANGE;
    return (raw > MAX) ? MAX : MIN;
  endfunction

  function automatic void model_edge(input int i, input bit r, input bit e, input bit md,
                                     input bit ld, input int lv);
    bit b1, b2;
    int v;
    b1 = 1'b0;
    b2 = 1'b0;
    m_bnd[i]  = 1'b0;
    m_skp[i]  = 1'b0;
    m_lerr[i] = 1'b0;
    if (!r) begin
      m_cnt[i] = RSTV;
    end else if (ld) begin
      if (lv >= MIN && lv <= MAX && lv != SKIP) m_cnt[i] = lv;
      else                                      m_lerr[i] = 1'b1;
    end else if (e) begin
      v = fold_m(md ? m_cnt[i] + UP : m_cnt[i] - DN, i == 1, b1);
      if (v == SKIP) begin
        m_skp[i] = 1'b1;
        v = fold_m(md ? SKIP + UP : SKIP - DN, i == 1, b2);
      end
      m_bnd[i] = b1 | b2;
      m_cnt[i] = v;
    end
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("d0.cnt",       32'(bus0.cnt),       m_cnt[0]);
    check("d0.at_max",    32'(bus0.at_max),    int'(m_cnt[0] == MAX));
    check("d0.at_min",    32'(bus0.at_min),    int'(m_cnt[0] == MIN));
    check("d0.bound_evt", 32'(bus0.bound_evt), int'(m_bnd[0]));
    check("d0.skip_evt",  32'(bus0.skip_evt),  int'(m_skp[0]));
    check("d0.load_err",  32'(bus0.load_err),  int'(m_lerr[0]));
    check("d1.cnt",       32'(bus1.cnt),       m_cnt[1]);
    check("d1.at_max",    32'(bus1.at_max),    int'(m_cnt[1] == MAX));
    check("d1.at_min",    32'(bus1.at_min),    int'(m_cnt[1] == MIN));
    check("d1.bound_evt", 32'(bus1.bound_evt), int'(m_bnd[1]));
    check("d1.skip_evt",  32'(bus1.skip_evt),  int'(m_skp[1]));
    check("d1.load_err",  32'(bus1.load_err),  int'(m_lerr[1]));
  endtask

  // One clock: drive both instances identically, advance the model, sample 1 ns later.
  task automatic cycle(input bit r, input bit e, input bit md, input bit ld, input int lv);
    rst           = r;
    bus0.en       = e;
    bus0.mode     = md;
    bus0.load     = ld;
    bus0.load_val = W'(lv);
    bus1.en       = e;
    bus1.mode     = md;
    bus1.load     = ld;
    bus1.load_val = W'(lv);
    @(posedge clk);
    model_edge(0, r, e, md, ld, lv);
    model_edge(1, r, e, md, ld, lv);
    #1;
    check_all();
  endtask

  initial begin
    bit r, e, md, ld;
    int lv;

    // Reset held two cycles while load is requested: reset wins.
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 100);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 100);
    check("rst.cnt", 32'(bus0.cnt), 17);
    check("rst.at_max", 32'(bus0.at_max), 0);

    // Up run from 17 to the top bound, then saturate.
    repeat (62) cycle(1'b1, 1'b1, 1'b1, 1'b0, 0);
    check("up.265", 32'(bus0.cnt), 265);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 0);
    check("up.269", 32'(bus0.cnt), 269);
    check("up.269.at_max", 32'(bus0.at_max), 1);
    check("up.269.bound", 32'(bus0.bound_evt), 0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 0);
    check("up.sat.cnt", 32'(bus0.cnt), 269);
    check("up.sat.bound", 32'(bus0.bound_evt), 1);

    // Skip over -47 in both directions.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, -51);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 0);
    check("skip.up.cnt", 32'(bus0.cnt), -43);
    check("skip.up.evt", 32'(bus0.skip_evt), 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, -37);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 0);
    check("skip.dn.cnt", 32'(bus0.cnt), -57);
    check("skip.dn.evt", 32'(bus0.skip_evt), 1);
    check("skip.never", 32'(bus0.cnt == W'(SKIP)), 0);

    // Down saturation and hold at the bottom.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, -255);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 0);
    check("dn.sat.cnt", 32'(bus0.cnt), -263);
    check("dn.sat.bound", 32'(bus0.bound_evt), 1);
    check("dn.sat.at_min", 32'(bus0.at_min), 1);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0, 0);
    check("dn.hold", 32'(bus0.cnt), -263);

    // Load rejection and acceptance at the bound.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 300);
    check("ld.300.err", 32'(bus0.load_err), 1);
    check("ld.300.cnt", 32'(bus0.cnt), 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, -47);
    check("ld.skip.err", 32'(bus0.load_err), 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, -263);
    check("ld.min.cnt", 32'(bus0.cnt), -263);
    check("ld.min.at_min", 32'(bus0.at_min), 1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 0);

    // Wrapping instance across both bounds, then reset mid-run.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 267);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 0);
    check("wrap.up.cnt", 32'(bus1.cnt), -262);
    check("wrap.up.bound", 32'(bus1.bound_evt), 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, -258);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 0);
    check("wrap.dn.cnt", 32'(bus1.cnt), 265);
    check("wrap.dn.bound", 32'(bus1.bound_evt), 1);
    repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b0, 0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 100);
    check("wrap.rst.cnt", 32'(bus1.cnt), 17);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 49) != 0);
      e  = ($urandom_range(0, 3) != 0);
      md = 1'($urandom_range(0, 1));
      ld = ($urandom_range(0, 5) == 0);
      lv = int'($urandom_range(0, 600)) - 300;
      if ($urandom_range(0, 7) == 0) lv = SKIP;
      cycle(r, e, md, ld, lv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
